mmc_arbiter: RTL

Round-robin arbiter and sequencer that shares one iterative LCM (mmc) datapath among `N_REQ` requesters. It accepts one request at a time and loads the winner's operands into the core. It then runs the add-and-compare iteration to completion and returns the result with a one-hot response strobe. It sits between the requester blocks and a single `mmc_core` instance, replacing per-requester LCM units.

---
 rtl/mmc_pkg.sv | 33 +++
 rtl/mmc_core.sv | 71 +++++++
 rtl/mmc_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mmc_pkg.sv
// Shared types, default sizes and round-robin pick helper for the mmc arbiter slice.
package mmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MMC_WIDTH   = 32;
  localparam int MMC_N_REQ   = 4;
  localparam int MMC_MAX_REQ = 32;

  // First set bit of req at or above ptr, wrapping modulo n; 0 when none set.
  function automatic int unsigned rr_pick(input logic [MMC_MAX_REQ-1:0] req,
                                          input int unsigned n,
                                          input int unsigned ptr);
    int unsigned idx;
    logic        found;
    rr_pick = 32'd0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MMC_MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (!found && (k < n) && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/mmc_core.sv
// Iterative LCM datapath: A/B accumulators stepping by the original operands IA/IB.
module mmc_core
  import mmc_pkg::*;
#(
  parameter int WIDTH = MMC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  output logic [WIDTH-1:0] a,
  output logic             eq,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ia_q, ia_d, ib_q, ib_d;
  logic [WIDTH:0]   sum_a_s, sum_b_s;
  logic             a_lt_b_s;

  // Adders and compare; ovf reports the carry of whichever sum the next step would take.
  always_comb begin
    sum_a_s  = {1'b0, a_q} + {1'b0, ia_q};
    sum_b_s  = {1'b0, b_q} + {1'b0, ib_q};
    a_lt_b_s = (a_q < b_q);
    eq       = (a_q == b_q);
    zero     = (a_q == '0) || (b_q == '0);
    ovf      = a_lt_b_s ? sum_a_s[WIDTH] : sum_b_s[WIDTH];
    a        = a_q;
  end

  // Next-state for the operand registers.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    ia_d = ia_q;
    ib_d = ib_q;
    if (load) begin
      a_d  = ld_a;
      b_d  = ld_b;
      ia_d = ld_a;
      ib_d = ld_b;
    end else if (step) begin
      if (a_lt_b_s) begin
        a_d = sum_a_s[WIDTH-1:0];
      end else begin
        b_d = sum_b_s[WIDTH-1:0];
      end
    end else begin
      a_d = a_q;
    end
  end

  // Operand register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ia_q <= '0;
      ib_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      ia_q <= ia_d;
      ib_q <= ib_d;
    end
  end

endmodule

// File: rtl/mmc_arbiter.sv
// Round-robin arbiter sequencing one shared mmc_core among N_REQ requesters.
// Optional iteration timeout is built when MMC_ARB_TIMEOUT_EN is defined.
module mmc_arbiter
  import mmc_pkg::*;
#(
  parameter int N_REQ   = MMC_N_REQ,
  parameter int WIDTH   = MMC_WIDTH,
  parameter int MAX_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       res,
  output logic                   ovf,
  output logic                   tmo
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > MMC_MAX_REQ || MAX_CYC < 1) begin : g_bad_cfg
    $error("mmc_arbiter: unsupported N_REQ or MAX_CYC");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, cur_q, cur_d, pick_s;
  logic [N_REQ-1:0] gnt_q, gnt_d, rsp_q, rsp_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d, busy_q, busy_d;
  logic             load_s, step_s, tmo_hit_s;
  logic [WIDTH-1:0] core_a_s;
  logic             core_eq_s, core_zero_s, core_ovf_s;

  mmc_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .step  (step_s),
    .ld_a  (op_a[pick_s*WIDTH +: WIDTH]),
    .ld_b  (op_b[pick_s*WIDTH +: WIDTH]),
    .a     (core_a_s),
    .eq    (core_eq_s),
    .zero  (core_zero_s),
    .ovf   (core_ovf_s)
  );

`ifdef MMC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // RUN-cycle counter; held at zero outside a transaction so it starts clean at grant.
  always_comb begin
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    tmo_hit_s = (cnt_q == CNT_W'(MAX_CYC));
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign pick_s = IDX_W'(rr_pick(MMC_MAX_REQ'(req), N_REQ, 32'(ptr_q)));

  // FSM next-state, grant/response and result update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    gnt_d   = '0;
    rsp_d   = '0;
    res_d   = res_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          cur_d   = pick_s;
          gnt_d   = N_REQ'(1) << pick_s;
          load_s  = 1'b1;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Termination priority: zero, equality, budget, then carry out of the step.
        if (core_zero_s || core_eq_s || tmo_hit_s || core_ovf_s) begin
          state_d = ST_DONE;
          rsp_d   = N_REQ'(1) << cur_q;
          res_d   = (!core_zero_s && core_eq_s) ? core_a_s : '0;
          tmo_d   = !core_zero_s && !core_eq_s && tmo_hit_s;
          ovf_d   = !core_zero_s && !core_eq_s && !tmo_hit_s && core_ovf_s;
        end else begin
          step_s  = 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = (cur_q == IDX_W'(N_REQ - 1)) ? '0 : cur_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      gnt_q   <= '0;
      rsp_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      gnt_q   <= gnt_d;
      rsp_q   <= rsp_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_q;
  assign res       = res_q;
  assign ovf       = ovf_q;
  assign tmo       = tmo_q;
  assign busy      = busy_q;

endmodule
